// File: rtl/interrupt_seq_pkg.sv
// Shared types and constants for the interrupt sequencer: sequence sources,
// FSM states, vector bases and pushed-byte select encodings.
package interrupt_seq_pkg;

    typedef enum logic [1:0] {
        SRC_RESET = 2'b00,
        SRC_NMI   = 2'b01,
        SRC_IRQ   = 2'b10,
        SRC_BRK   = 2'b11
    } src_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    localparam logic [1:0] WSEL_NONE = 2'b00;
    localparam logic [1:0] WSEL_PCH  = 2'b01;
    localparam logic [1:0] WSEL_PCL  = 2'b10;
    localparam logic [1:0] WSEL_P    = 2'b11;

    localparam logic [7:0] STACK_PAGE = 8'h01;

    // IRQ and BRK share a vector; the B bit is what tells them apart on the stack.
    function automatic logic [15:0] vectorBase(input src_t s);
        logic [15:0] base;
        case (s)
            SRC_NMI:   base = VEC_NMI;
            SRC_RESET: base = VEC_RESET;
            default:   base = VEC_IRQ;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/nmi_edge_latch.sv
// Rising-edge detector for nmi with a sticky pending flag; a clear consumes it,
// and any edge seen while it is already set is absorbed.
module nmi_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic nmi,
    input  logic clear,
    output logic pending
);

    logic r_nmiPrev;
    logic r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmiPrev <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_nmiPrev <= nmi;
            if (clear) begin
                r_pending <= 1'b0;
            end else if (nmi && !r_nmiPrev) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt/reset sequencer: seven-cycle push-and-vector sequence
// started at an instruction boundary, with NMI priority and NMI vector hijack.
module interrupt_sequencer
    import interrupt_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi,
    input  logic        irq,
    input  logic        i_flag,
    input  logic        instr_boundary,
    input  logic        brk,
    input  logic [7:0]  sp,
    input  logic [7:0]  data_in,
    output logic        seq_busy,
    output logic [2:0]  seq_cycle,
    output logic [1:0]  src,
    output logic [15:0] addr_out,
    output logic        write_en,
    output logic [1:0]  wdata_sel,
    output logic        b_flag,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load,
    output logic [15:0] vector_out
);

    state_t      r_state;
    state_t      w_stateNext;
    logic [2:0]  r_cycle;
    logic [2:0]  w_cycleNext;
    src_t        r_src;
    src_t        w_srcNext;
    logic        r_bFlag;
    logic        w_bFlagNext;
    logic [7:0]  r_vecLo;
    logic [15:0] r_vector;
    logic        r_pcLoad;
    logic        w_nmiPending;
    logic        w_nmiClear;
    logic [15:0] w_base;

    nmi_edge_latch u_nmiLatch (
        .clk     (clk),
        .rst     (rst),
        .nmi     (nmi),
        .clear   (w_nmiClear),
        .pending (w_nmiPending)
    );

    // Reset parks the FSM in cycle 1 of a RESET sequence so it runs on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_SEQ;
            r_cycle  <= 3'd1;
            r_src    <= SRC_RESET;
            r_bFlag  <= 1'b0;
            r_vecLo  <= 8'h00;
            r_vector <= 16'h0000;
            r_pcLoad <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cycle  <= w_cycleNext;
            r_src    <= w_srcNext;
            r_bFlag  <= w_bFlagNext;
            r_pcLoad <= (r_state == ST_SEQ) && (r_cycle == 3'd7);
            if ((r_state == ST_SEQ) && (r_cycle == 3'd6)) begin
                r_vecLo <= data_in;
            end
            if ((r_state == ST_SEQ) && (r_cycle == 3'd7)) begin
                r_vector <= {data_in, r_vecLo};
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cycleNext = r_cycle;
        w_srcNext   = r_src;
        w_bFlagNext = r_bFlag;
        w_nmiClear  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_boundary) begin
                    if (w_nmiPending) begin
                        w_stateNext = ST_SEQ;
                        w_cycleNext = 3'd1;
                        w_srcNext   = SRC_NMI;
                        w_bFlagNext = 1'b0;
                        w_nmiClear  = 1'b1;
                    end else if (irq && !i_flag) begin
                        w_stateNext = ST_SEQ;
                        w_cycleNext = 3'd1;
                        w_srcNext   = SRC_IRQ;
                        w_bFlagNext = 1'b0;
                    end else if (brk) begin
                        w_stateNext = ST_SEQ;
                        w_cycleNext = 3'd1;
                        w_srcNext   = SRC_BRK;
                        w_bFlagNext = 1'b1;
                    end
                end
            end
            ST_SEQ: begin
                if (r_cycle == 3'd7) begin
                    w_stateNext = ST_IDLE;
                    w_cycleNext = 3'd0;
                end else begin
                    w_cycleNext = r_cycle + 3'd1;
                    // Last chance to hijack: a pending NMI redirects the vector fetch
                    // but the already-pushed B bit stays as it was.
                    if ((r_cycle == 3'd5) && w_nmiPending &&
                        ((r_src == SRC_IRQ) || (r_src == SRC_BRK))) begin
                        w_srcNext  = SRC_NMI;
                        w_nmiClear = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cycleNext = 3'd0;
            end
        endcase
    end

    assign w_base = vectorBase(r_src);

    always_comb begin
        seq_busy  = (r_state == ST_SEQ);
        seq_cycle = r_cycle;
        src       = r_src;
        addr_out  = 16'h0000;
        write_en  = 1'b0;
        wdata_sel = WSEL_NONE;
        b_flag    = 1'b0;
        sp_dec    = 1'b0;
        set_i     = 1'b0;
        if (r_state == ST_SEQ) begin
            b_flag = r_bFlag;
            case (r_cycle)
                3'd1, 3'd2: begin
                    addr_out = {STACK_PAGE, sp};
                end
                3'd3: begin
                    addr_out  = {STACK_PAGE, sp};
                    sp_dec    = 1'b1;
                    write_en  = (r_src != SRC_RESET);
                    wdata_sel = WSEL_PCH;
                end
                3'd4: begin
                    addr_out  = {STACK_PAGE, sp};
                    sp_dec    = 1'b1;
                    write_en  = (r_src != SRC_RESET);
                    wdata_sel = WSEL_PCL;
                end
                3'd5: begin
                    addr_out  = {STACK_PAGE, sp};
                    sp_dec    = 1'b1;
                    write_en  = (r_src != SRC_RESET);
                    wdata_sel = WSEL_P;
                end
                3'd6: begin
                    addr_out = w_base;
                end
                3'd7: begin
                    addr_out = w_base + 16'd1;
                    set_i    = 1'b1;
                end
                default: begin
                    addr_out = 16'h0000;
                end
            endcase
        end
    end

    assign pc_load    = r_pcLoad;
    assign vector_out = r_vector;

endmodule
